// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_responder_pkg;

   localparam int WORD_W = 32;
   localparam int MASK_W = 4;
   // Wait counter holds 0..15.
   localparam int WCNT_W = $clog2(16);

   typedef enum logic {
      DM_IDLE = 1'b0,
      DM_WAIT = 1'b1
   } dm_state_e;

   // One captured core access.
   typedef struct packed {
      logic              we;
      logic [WORD_W-1:0] addr;
      logic [WORD_W-1:0] wdata;
      logic [MASK_W-1:0] wmask;
   } dm_req_t;

   // Window test done in 33 bits so that base+span never wraps.
   function automatic logic in_window(input logic [WORD_W-1:0] addr,
                                      input logic [WORD_W-1:0] base,
                                      input logic [WORD_W:0]   span);
      logic [WORD_W:0] a;
      logic [WORD_W:0] lo;
      a  = {1'b0, addr};
      lo = {1'b0, base};
      return (a >= lo) && (a < (lo + span));
   endfunction

endpackage

// File: rtl/dmem_sram_be.sv
// Single-port byte-enable RAM: synchronous write, synchronous read.
module dmem_sram_be
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter     INIT_FILE   = "",
  localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [MASK_W-1:0] be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Byte-lane writes on stores; read port only updates on loads.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int n = 0; n < MASK_W; n++) begin
          if (be[n]) mem[idx][8*n +: 8] <= wdata[8*n +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the core load/store port: request FSM, wait states,
// range decode and error reporting in front of a byte-enable RAM.
// Handshake: an access is accepted on a posedge where the FSM is idle and
// req_mem_i is high; data_stall_o stays high until the response cycle, in
// which rdata_o/data_err_o are valid and a new request may be accepted.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_STATES = 0,
   parameter              INIT_FILE   = ""
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_mem_i,
   input  logic              wmem_i,
   input  logic [WORD_W-1:0] addr_i,
   input  logic [WORD_W-1:0] wdata_i,
   input  logic [MASK_W-1:0] wmask_i,
   output logic [WORD_W-1:0] rdata_o,
   output logic              data_stall_o,
   output logic              data_err_o
);

   localparam int           IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [WORD_W:0] SPAN = (WORD_W+1)'(DEPTH_WORDS) << 2;

   dm_state_e         state_q, state_d;
   logic [WCNT_W-1:0] cnt_q, cnt_d;
   dm_req_t           req_q;
   dm_req_t           cur;
   logic              fire;
   logic              hit;
   logic [IDX_W-1:0]  idx;
   logic              err_q;
   logic              zero_q;
   logic [WORD_W-1:0] ram_rdata;

   // Request presented to the RAM: live inputs at accept, latched copy at end of WAIT.
   always_comb begin
      cur = req_q;
      if (state_q == DM_IDLE) begin
         cur = '{we: wmem_i, addr: addr_i, wdata: wdata_i, wmask: wmask_i};
      end
   end

   assign hit = in_window(cur.addr, BASE_ADDR, SPAN);
   assign idx = cur.addr[IDX_W+1:2] - BASE_ADDR[IDX_W+1:2];

   // Next state, wait countdown and the edge on which the access is performed.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fire    = 1'b0;
      case (state_q)
         DM_IDLE: begin
            if (req_mem_i) begin
               if (WAIT_STATES == 0) begin
                  fire = 1'b1;
               end else begin
                  state_d = DM_WAIT;
                  cnt_d   = WCNT_W'(WAIT_STATES - 1);
               end
            end
         end
         DM_WAIT: begin
            if (cnt_q == '0) begin
               fire    = 1'b1;
               state_d = DM_IDLE;
            end else begin
               cnt_d = cnt_q - WCNT_W'(1);
            end
         end
         default: state_d = DM_IDLE;
      endcase
      // Reset drops any pending or simultaneous access.
      if (reset) fire = 1'b0;
   end

   // State, counter and response flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= DM_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         zero_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= fire & ~hit;
         if (fire) begin
            if (!hit)        zero_q <= 1'b1;
            else if (!cur.we) zero_q <= 1'b0;
         end
      end
   end

   // Capture the request on acceptance so WAIT does not depend on the core holding it.
   always_ff @(posedge clk) begin
      if (state_q == DM_IDLE && req_mem_i) begin
         req_q <= '{we: wmem_i, addr: addr_i, wdata: wdata_i, wmask: wmask_i};
      end
   end

   dmem_sram_be #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .INIT_FILE   (INIT_FILE)
   ) u_sram (
      .clk   (clk),
      .en    (fire & hit),
      .we    (cur.we),
      .be    (cur.wmask),
      .idx   (idx),
      .wdata (cur.wdata),
      .rdata (ram_rdata)
   );

   // RAM read register holds the last load; zero_q forces 0 after reset or a fault.
   assign rdata_o      = zero_q ? '0 : ram_rdata;
   assign data_stall_o = (state_q == DM_WAIT);
   assign data_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (0, 2 and 3 wait states) driven
// in turn; expected responses are queued with their due cycle and checked
// by an independent monitor.
module tb_dmem_responder;

   localparam logic [31:0] BASE  = 32'h0000_2000;
   localparam int          DEPTH = 64;
   localparam logic [31:0] TOP   = BASE + 32'(4 * DEPTH);

   typedef struct {
      int          inst;
      int          due;
      logic [31:0] rd;
      logic        chk_rd;
      logic        err;
      string       name;
   } exp_t;

   exp_t exp_q[$];

   logic        clk;
   logic        rst   [3];
   logic        req   [3];
   logic        we    [3];
   logic [31:0] addr  [3];
   logic [31:0] wdata [3];
   logic [3:0]  mask  [3];
   logic [31:0] rdata [3];
   logic        stall [3];
   logic        err   [3];

   int tests  = 0;
   int fails  = 0;
   int cyc    = 0;
   logic mon_en = 1'b0;

   // ---------------- clock / cycle count ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUTs ----------------
   dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .INIT_FILE("")) u_w0 (
      .clk(clk), .reset(rst[0]), .req_mem_i(req[0]), .wmem_i(we[0]), .addr_i(addr[0]),
      .wdata_i(wdata[0]), .wmask_i(mask[0]), .rdata_o(rdata[0]), .data_stall_o(stall[0]),
      .data_err_o(err[0]));

   dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(2), .INIT_FILE("")) u_w2 (
      .clk(clk), .reset(rst[1]), .req_mem_i(req[1]), .wmem_i(we[1]), .addr_i(addr[1]),
      .wdata_i(wdata[1]), .wmask_i(mask[1]), .rdata_o(rdata[1]), .data_stall_o(stall[1]),
      .data_err_o(err[1]));

   dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(3), .INIT_FILE("")) u_w3 (
      .clk(clk), .reset(rst[2]), .req_mem_i(req[2]), .wmem_i(we[2]), .addr_i(addr[2]),
      .wdata_i(wdata[2]), .wmask_i(mask[2]), .rdata_o(rdata[2]), .data_stall_o(stall[2]),
      .data_err_o(err[2]));

   function automatic int w_of(input int i);
      return (i == 0) ? 0 : ((i == 1) ? 2 : 3);
   endfunction

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request, queue its response, and hold it through the stall
   // cycles. Returns in the response cycle with the request still asserted.
   task automatic issue(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, input logic [31:0] erd, input logic chk,
                        input logic eerr, input string name);
      exp_t e;
      req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d; mask[i] = m;
      e.inst = i; e.due = cyc + 1 + w_of(i); e.rd = erd; e.chk_rd = chk; e.err = eerr; e.name = name;
      exp_q.push_back(e);
      tick();
      for (int k = 0; k < w_of(i); k++) begin
         check({name, "_stall"}, 32'(stall[i]), 32'd1);
         tick();
      end
   endtask

   task automatic idle(input int i);
      req[i] = 1'b0; we[i] = 1'b0; mask[i] = 4'h0;
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (mon_en) begin
         while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            tests++;
            fails++;
            $display("FAIL %s_missing: response due cycle %0d not seen", exp_q[0].name, exp_q[0].due);
            void'(exp_q.pop_front());
         end
         for (int i = 0; i < 3; i++) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc && exp_q[0].inst == i) begin
               check({exp_q[0].name, "_err"},   32'(err[i]),   32'(exp_q[0].err));
               check({exp_q[0].name, "_rstall"}, 32'(stall[i]), 32'd0);
               if (exp_q[0].chk_rd) check({exp_q[0].name, "_rdata"}, rdata[i], exp_q[0].rd);
               void'(exp_q.pop_front());
            end else begin
               check($sformatf("idle_err%0d", i), 32'(err[i]), 32'd0);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b1; req[i] = 1'b0; we[i] = 1'b0;
         addr[i] = '0; wdata[i] = '0; mask[i] = '0;
      end
      repeat (3) tick();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst_rdata%0d", i), rdata[i], 32'h0);
         check($sformatf("rst_stall%0d", i), 32'(stall[i]), 32'd0);
         check($sformatf("rst_err%0d", i),   32'(err[i]),   32'd0);
         rst[i] = 1'b0;
      end
      mon_en = 1'b1;
      tick();

      // ---- zero wait states: byte lanes and read-after-write ----
      issue(0, 1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, '0, 1'b0, 1'b0, "st_full");
      issue(0, 1'b0, BASE + 32'h10, '0, 4'h0, 32'hDEADBEEF, 1'b1, 1'b0, "ld_full");
      issue(0, 1'b1, BASE + 32'h10, 32'h0000AA00, 4'b0010, '0, 1'b0, 1'b0, "st_lane1");
      issue(0, 1'b0, BASE + 32'h10, '0, 4'h0, 32'hDEADAAEF, 1'b1, 1'b0, "ld_lane1");
      issue(0, 1'b1, BASE + 32'h10, 32'h11111111, 4'b0000, '0, 1'b0, 1'b0, "st_nomask");
      issue(0, 1'b0, BASE + 32'h10, '0, 4'h0, 32'hDEADAAEF, 1'b1, 1'b0, "ld_nomask");
      idle(0);
      tick();

      // ---- zero wait states: back-to-back stores then loads ----
      for (int k = 0; k < 4; k++)
         issue(0, 1'b1, BASE + 32'(4 * k), 32'hA000_0000 + 32'(k), 4'hF, '0, 1'b0, 1'b0, "st_b2b");
      issue(0, 1'b1, TOP - 32'h4, 32'h5555AAAA, 4'hF, '0, 1'b0, 1'b0, "st_last");
      idle(0);
      tick();
      for (int k = 0; k < 4; k++) begin
         issue(0, 1'b0, BASE + 32'(4 * k), '0, 4'h0, 32'hA000_0000 + 32'(k), 1'b1, 1'b0, "ld_b2b");
         check("b2b_stall", 32'(stall[0]), 32'd0);
      end
      idle(0);
      tick();

      // ---- out-of-window accesses ----
      issue(0, 1'b1, TOP,           32'hFFFFFFFF, 4'hF, '0, 1'b1, 1'b1, "st_top");
      issue(0, 1'b0, BASE - 32'h4,  '0, 4'h0, 32'h0, 1'b1, 1'b1, "ld_below");
      issue(0, 1'b1, BASE - 32'h4,  32'h0, 4'hF, '0, 1'b1, 1'b1, "st_below");
      issue(0, 1'b0, 32'hFFFF_FFFC, '0, 4'h0, 32'h0, 1'b1, 1'b1, "ld_wrap");
      issue(0, 1'b0, 32'h0000_0000, '0, 4'h0, 32'h0, 1'b1, 1'b1, "ld_zero");
      idle(0);
      tick();
      issue(0, 1'b0, BASE,          '0, 4'h0, 32'hA0000000, 1'b1, 1'b0, "ld_word0_kept");
      issue(0, 1'b0, TOP - 32'h4,   '0, 4'h0, 32'h5555AAAA, 1'b1, 1'b0, "ld_last_kept");
      idle(0);
      repeat (3) tick();

      // ---- two wait states: stall window, held request, fault ----
      issue(1, 1'b1, BASE + 32'h10, 32'h0BADF00D, 4'hF, '0, 1'b0, 1'b0, "w2_st");
      issue(1, 1'b0, BASE + 32'h10, '0, 4'h0, 32'h0BADF00D, 1'b1, 1'b0, "w2_ld");
      idle(1);
      tick();
      check("w2_no_reaccept", 32'(stall[1]), 32'd0);
      issue(1, 1'b0, BASE - 32'h4, '0, 4'h0, 32'h0, 1'b1, 1'b1, "w2_ld_below");
      idle(1);
      repeat (3) tick();

      // ---- three wait states: reset during stall drops the store ----
      issue(2, 1'b1, BASE, 32'hCAFEF00D, 4'hF, '0, 1'b0, 1'b0, "w3_st_old");
      idle(2);
      tick();
      req[2] = 1'b1; we[2] = 1'b1; addr[2] = BASE; wdata[2] = 32'h12345678; mask[2] = 4'hF;
      tick();
      check("w3_first_stall", 32'(stall[2]), 32'd1);
      rst[2] = 1'b1;
      idle(2);
      tick();
      check("w3_rst_stall", 32'(stall[2]), 32'd0);
      check("w3_rst_err",   32'(err[2]),   32'd0);
      check("w3_rst_rdata", rdata[2],      32'h0);
      rst[2] = 1'b0;
      repeat (2) tick();
      check("w3_after_rst_stall", 32'(stall[2]), 32'd0);
      issue(2, 1'b0, BASE, '0, 4'h0, 32'hCAFEF00D, 1'b1, 1'b0, "w3_ld_old");
      idle(2);
      repeat (6) tick();

      check("drain", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
